// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer
//  Purpose  : In-order commit buffer placed after the rename stage. Records
//             each renamed instruction's architectural destination, its new
//             physical register and the physical register it displaced.
//             Completion arrives out of order by tag. Retirement is in
//             program order at up to one entry per cycle. A retired entry's
//             displaced physical register is presented on
//             retire_valid/retire_phys_reg, which drives the free-list
//             release port.
//  Options  : ROB_COMPLETE_BYPASS_EN - when defined, a completion aimed at
//             the head entry retires it on the same edge.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             alloc_*               - allocation request / ready / tag
//             complete_valid/_tag   - out-of-order completion by tag
//             retire_*              - registered retirement outputs
//             rob_empty/full/count  - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int PHYS_W = 6,
    parameter int ARCH_W = 5,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    input  logic [ARCH_W-1:0] alloc_rd,
    input  logic [PHYS_W-1:0] alloc_phys_rd,
    input  logic [PHYS_W-1:0] alloc_old_phys_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              complete_valid,
    input  logic [TAG_W-1:0]  complete_tag,
    output logic              retire_valid,
    output logic [PHYS_W-1:0] retire_phys_reg,
    output logic [ARCH_W-1:0] retire_rd,
    output logic [TAG_W-1:0]  retire_tag,
    output logic              rob_empty,
    output logic              rob_full,
    output logic [TAG_W:0]    rob_count
);

    localparam logic [TAG_W:0] c_PTR_ONE = (TAG_W+1)'(1);

    // Per-entry storage
    logic              r_valid       [DEPTH];
    logic              r_done        [DEPTH];
    logic [ARCH_W-1:0] r_rd          [DEPTH];
    logic [PHYS_W-1:0] r_phys_rd     [DEPTH];
    logic [PHYS_W-1:0] r_old_phys_rd [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [TAG_W:0] r_head;
    logic [TAG_W:0] r_tail;

    logic [TAG_W-1:0] w_head_idx;
    logic [TAG_W-1:0] w_tail_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_alloc;
    logic             w_head_ready;
    logic             w_retire;

    assign w_head_idx = r_head[TAG_W-1:0];
    assign w_tail_idx = r_tail[TAG_W-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (w_head_idx == w_tail_idx) && (r_head[TAG_W] != r_tail[TAG_W]);

    // A full buffer refuses allocation even when it retires in the same cycle
    assign w_alloc    = alloc_valid && !w_full;

`ifdef ROB_COMPLETE_BYPASS_EN
    // A completion aimed at the head makes it eligible without waiting a
    // cycle for the done bit to be written.
    assign w_head_ready = r_done[w_head_idx] ||
                          (complete_valid && (complete_tag == w_head_idx));
`else
    assign w_head_ready = r_done[w_head_idx];
`endif

    assign w_retire = r_valid[w_head_idx] && w_head_ready;

    // Status outputs
    assign rob_count   = r_tail - r_head;
    assign rob_empty   = w_empty;
    assign rob_full    = w_full;
    assign alloc_ready = !w_full;
    assign alloc_tag   = w_tail_idx;

    // Pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_retire) begin
                r_head <= r_head + c_PTR_ONE;
            end
        end
    end

    // Entry control bits. The later assignments take precedence: retirement
    // clears the head even if a repeat completion hits it in the same cycle,
    // and allocation forces done=0 over a same-cycle completion of that tag.
    // Allocation and retirement never target the same index, because the
    // head is only valid when the buffer is non-empty, and a non-empty buffer
    // can only allocate onto its head index when full, which blocks the
    // allocation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_done[i]  <= 1'b0;
            end
        end else begin
            if (complete_valid && r_valid[complete_tag]) begin
                r_done[complete_tag] <= 1'b1;
            end
            if (w_retire) begin
                r_valid[w_head_idx] <= 1'b0;
                r_done[w_head_idx]  <= 1'b0;
            end
            if (w_alloc) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_done[w_tail_idx]  <= 1'b0;
            end
        end
    end

    // Entry payload. It is qualified by the valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_rd[w_tail_idx]          <= alloc_rd;
            r_phys_rd[w_tail_idx]     <= alloc_phys_rd;
            r_old_phys_rd[w_tail_idx] <= alloc_old_phys_rd;
        end
    end

    // Retirement outputs. The payload holds its last value between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_valid    <= 1'b0;
            retire_phys_reg <= '0;
            retire_rd       <= '0;
            retire_tag      <= '0;
        end else begin
            retire_valid <= w_retire;
            if (w_retire) begin
                retire_phys_reg <= r_old_phys_rd[w_head_idx];
                retire_rd       <= r_rd[w_head_idx];
                retire_tag      <= w_head_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reorder_buffer
//  Purpose  : Self-checking bench for reorder_buffer. Directed stimulus
//             pushes the expected retirement records into a scoreboard
//             queue. A monitor pops and compares one record on every
//             retire_valid pulse. Status outputs are checked inline.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int PHYS_W = 6;
    localparam int ARCH_W = 5;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_valid;
    logic [ARCH_W-1:0] alloc_rd;
    logic [PHYS_W-1:0] alloc_phys_rd;
    logic [PHYS_W-1:0] alloc_old_phys_rd;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              complete_valid;
    logic [TAG_W-1:0]  complete_tag;
    logic              retire_valid;
    logic [PHYS_W-1:0] retire_phys_reg;
    logic [ARCH_W-1:0] retire_rd;
    logic [TAG_W-1:0]  retire_tag;
    logic              rob_empty;
    logic              rob_full;
    logic [TAG_W:0]    rob_count;

    reorder_buffer #(
        .DEPTH (DEPTH),
        .PHYS_W(PHYS_W),
        .ARCH_W(ARCH_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .alloc_valid      (alloc_valid),
        .alloc_rd         (alloc_rd),
        .alloc_phys_rd    (alloc_phys_rd),
        .alloc_old_phys_rd(alloc_old_phys_rd),
        .alloc_ready      (alloc_ready),
        .alloc_tag        (alloc_tag),
        .complete_valid   (complete_valid),
        .complete_tag     (complete_tag),
        .retire_valid     (retire_valid),
        .retire_phys_reg  (retire_phys_reg),
        .retire_rd        (retire_rd),
        .retire_tag       (retire_tag),
        .rob_empty        (rob_empty),
        .rob_full         (rob_full),
        .rob_count        (rob_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PHYS_W-1:0] phys;
        logic [ARCH_W-1:0] rd;
        logic [TAG_W-1:0]  tag;
    } ret_t;

    ret_t exp_q[$];

    // Bench-side copy of what was allocated to each tag
    logic [ARCH_W-1:0] m_rd  [DEPTH];
    logic [PHYS_W-1:0] m_old [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input int exp_tag, input int rd, input int phys, input int old);
        chk("alloc_tag", int'(alloc_tag), exp_tag);
        alloc_valid       = 1'b1;
        alloc_rd          = ARCH_W'(rd);
        alloc_phys_rd     = PHYS_W'(phys);
        alloc_old_phys_rd = PHYS_W'(old);
        m_rd[exp_tag]     = ARCH_W'(rd);
        m_old[exp_tag]    = PHYS_W'(old);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic expect_retire(input int tag);
        ret_t r;
        r.phys = m_old[tag];
        r.rd   = m_rd[tag];
        r.tag  = TAG_W'(tag);
        exp_q.push_back(r);
    endtask

    task automatic do_complete(input int tag);
        complete_valid = 1'b1;
        complete_tag   = TAG_W'(tag);
        tick();
        complete_valid = 1'b0;
    endtask

    task automatic wait_count(input string name, input int target);
        for (int i = 0; i < 64 && int'(rob_count) != target; i++) tick();
        chk(name, int'(rob_count), target);
    endtask

    // Monitor: every retirement pulse must match the oldest expected record
    always @(negedge clk) begin
        if (retire_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_retire_tag", int'(retire_tag), -1);
            end else begin
                ret_t e;
                e = exp_q.pop_front();
                chk("retire_phys_reg", int'(retire_phys_reg), int'(e.phys));
                chk("retire_rd",       int'(retire_rd),       int'(e.rd));
                chk("retire_tag",      int'(retire_tag),      int'(e.tag));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        alloc_valid    = 1'b0;
        alloc_rd       = '0;
        alloc_phys_rd  = '0;
        alloc_old_phys_rd = '0;
        complete_valid = 1'b0;
        complete_tag   = '0;
        tick();
        tick();
        reset = 1'b0;

        // ---------------- reset state ----------------
        chk("rst_count",        int'(rob_count), 0);
        chk("rst_empty",        int'(rob_empty), 1);
        chk("rst_full",         int'(rob_full), 0);
        chk("rst_alloc_ready",  int'(alloc_ready), 1);
        chk("rst_alloc_tag",    int'(alloc_tag), 0);
        chk("rst_retire_valid", int'(retire_valid), 0);
        chk("rst_retire_phys",  int'(retire_phys_reg), 0);
        chk("rst_retire_rd",    int'(retire_rd), 0);
        chk("rst_retire_tag",   int'(retire_tag), 0);

        // ---------------- out-of-order completion ----------------
        for (int i = 0; i < 4; i++) do_alloc(i, i + 1, 20 + i, 10 + i);
        chk("ooo_count", int'(rob_count), 4);
        for (int t = 3; t >= 1; t--) begin
            do_complete(t);
            chk("ooo_no_retire", int'(retire_valid), 0);
        end
        for (int t = 0; t < 4; t++) expect_retire(t);
        do_complete(0);
`ifndef ROB_COMPLETE_BYPASS_EN
        chk("ooo_lat_wait", int'(retire_valid), 0);
        tick();
`endif
        for (int k = 0; k < 4; k++) begin
            chk("ooo_consecutive", int'(retire_valid), 1);
            tick();
        end
        chk("ooo_after", int'(retire_valid), 0);
        chk("ooo_empty", int'(rob_empty), 1);
        // head=tail=4 now; reset back to tag 0 for the fill test
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // ---------------- fill and overflow ----------------
        for (int i = 0; i < 16; i++) do_alloc(i, i, 32 + i, 30 + i);
        chk("full_flag",   int'(rob_full), 1);
        chk("full_ready",  int'(alloc_ready), 0);
        chk("full_count",  int'(rob_count), 16);
        alloc_valid = 1'b1;
        alloc_old_phys_rd = 6'd63;
        alloc_rd = 5'd31;
        tick();
        alloc_valid = 1'b0;
        chk("overflow_count", int'(rob_count), 16);
        chk("overflow_tag",   int'(alloc_tag), 0);

        // ---------------- wrap-around ----------------
        for (int t = 0; t < 10; t++) begin
            expect_retire(t);
            do_complete(t);
        end
        wait_count("wrap_retire10", 6);
        for (int i = 0; i < 8; i++) do_alloc(i, 31 - i, i, 50 + i);
        chk("wrap_count", int'(rob_count), 14);
        for (int k = 0; k < 14; k++) begin
            int t;
            t = (10 + k) % 16;
            expect_retire(t);
            do_complete(t);
        end
        wait_count("wrap_drain", 0);
        chk("wrap_empty", int'(rob_empty), 1);
        chk("wrap_tail",  int'(alloc_tag), 8);

        // ---------------- simultaneous alloc + retire at count 5 ----------------
        for (int i = 8; i < 13; i++) do_alloc(i, i, i, i + 1);
        chk("sim_count_before", int'(rob_count), 5);
        expect_retire(8);
        m_rd[13]  = 5'd13;
        m_old[13] = 6'd14;
        complete_valid = 1'b1;
        complete_tag   = 4'd8;
`ifndef ROB_COMPLETE_BYPASS_EN
        tick();
        complete_valid = 1'b0;
`endif
        alloc_valid       = 1'b1;
        alloc_rd          = 5'd13;
        alloc_phys_rd     = 6'd13;
        alloc_old_phys_rd = 6'd14;
        tick();
        alloc_valid    = 1'b0;
        complete_valid = 1'b0;
        chk("sim_retire",    int'(retire_valid), 1);
        chk("sim_count",     int'(rob_count), 5);
        chk("sim_tail",      int'(alloc_tag), 14);

        // ---------------- mid-stream reset with 4 in flight ----------------
        expect_retire(9);
        do_complete(9);
        wait_count("pre_reset_count", 4);
        reset          = 1'b1;
        complete_valid = 1'b1;
        complete_tag   = 4'd10;
        alloc_valid    = 1'b1;
        tick();
        reset          = 1'b0;
        complete_valid = 1'b0;
        alloc_valid    = 1'b0;
        chk("mrst_count",  int'(rob_count), 0);
        chk("mrst_retire", int'(retire_valid), 0);
        chk("mrst_empty",  int'(rob_empty), 1);
        chk("mrst_tag",    int'(alloc_tag), 0);

        // ---------------- completion of an invalid tag ----------------
        do_complete(7);
        chk("inv_count",  int'(rob_count), 0);
        chk("inv_empty",  int'(rob_empty), 1);
        chk("inv_retire", int'(retire_valid), 0);
        chk("inv_tag",    int'(alloc_tag), 0);

        // ---------------- single-entry completion latency ----------------
        do_alloc(0, 3, 4, 33);
        tick();
        expect_retire(0);
        do_complete(0);
`ifdef ROB_COMPLETE_BYPASS_EN
        chk("lat_edge_n", int'(retire_valid), 1);
`else
        chk("lat_edge_n", int'(retire_valid), 0);
        tick();
        chk("lat_edge_n1", int'(retire_valid), 1);
`endif
        tick();
        chk("lat_after", int'(retire_valid), 0);
        chk("lat_empty", int'(rob_empty), 1);

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
